// File: rtl/freq_input_conditioner.sv
// Per-channel pin conditioner: 2-flop synchroniser, glitch filter, rising-edge pulse, activity flag.
// Optional activity monitor is compiled in with `define FREQ_INPUT_ACTIVITY_EN.
module freq_input_conditioner #(
    parameter int INPUTS_COUNT     = 24,
    parameter int FILTER_LEN       = 4,
    parameter int ACTIVITY_TIMEOUT = 65536
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [INPUTS_COUNT-1:0] F_raw,
    input  logic                    filter_bypass_i,
    output logic [INPUTS_COUNT-1:0] F_in,
    output logic [INPUTS_COUNT-1:0] F_rise,
    output logic [INPUTS_COUNT-1:0] active_o
);

    localparam int                CNT_W   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(FILTER_LEN - 1);

    logic [INPUTS_COUNT-1:0]            s1_q, s1_d;
    logic [INPUTS_COUNT-1:0]            s2_q, s2_d;
    logic [INPUTS_COUNT-1:0]            f_in_q, f_in_d;
    logic [INPUTS_COUNT-1:0]            f_rise_q, f_rise_d;
    logic [INPUTS_COUNT-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [INPUTS_COUNT-1:0]            rise_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        s1_d   = F_raw;
        s2_d   = s1_q;
        f_in_d = f_in_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < INPUTS_COUNT; i++) begin
            if (filter_bypass_i) begin
                f_in_d[i] = s2_q[i];
                cnt_d[i]  = '0;
            end else if (s2_q[i] == f_in_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                f_in_d[i] = s2_q[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        rise_d   = f_in_d & ~f_in_q;
        f_rise_d = rise_d;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q     <= '0;
            s2_q     <= '0;
            f_in_q   <= '0;
            f_rise_q <= '0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            f_in_q   <= f_in_d;
            f_rise_q <= f_rise_d;
            cnt_q    <= cnt_d;
        end
    end

    assign F_in   = f_in_q;
    assign F_rise = f_rise_q;

`ifdef FREQ_INPUT_ACTIVITY_EN
    localparam logic [19:0] ACT_MAX = 20'(ACTIVITY_TIMEOUT - 1);

    logic [INPUTS_COUNT-1:0][19:0] act_q, act_d;
    logic [INPUTS_COUNT-1:0]       active_q, active_d;

    // A rise in the timeout cycle takes priority, keeping the channel active.
    always_comb begin
        act_d    = act_q;
        active_d = active_q;
        for (int i = 0; i < INPUTS_COUNT; i++) begin
            if (rise_d[i]) begin
                act_d[i]    = '0;
                active_d[i] = 1'b1;
            end else if (act_q[i] == ACT_MAX) begin
                active_d[i] = 1'b0;
            end else begin
                act_d[i] = act_q[i] + 20'd1;
            end
        end
    end

    // Counters reset saturated so every channel starts out inactive.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < INPUTS_COUNT; i++) begin
                act_q[i] <= ACT_MAX;
            end
            active_q <= '0;
        end else begin
            act_q    <= act_d;
            active_q <= active_d;
        end
    end

    assign active_o = active_q;
`else
    assign active_o = '1;
`endif

endmodule

// File: tb/tb_freq_input_conditioner.sv
// Directed bench for freq_input_conditioner: reset, filter latency, glitch rejection, bypass, activity.
// Expectations follow FREQ_INPUT_ACTIVITY_EN if the macro is defined for the build.
module tb_freq_input_conditioner;

    localparam int N  = 24;
    localparam int FL = 4;
    localparam int TO = 64;

    logic         clk_i;
    logic         rst_i;
    logic [N-1:0] F_raw;
    logic         filter_bypass_i;
    logic [N-1:0] F_in;
    logic [N-1:0] F_rise;
    logic [N-1:0] active_o;

    int n_checks = 0;
    int n_errors = 0;

`ifdef FREQ_INPUT_ACTIVITY_EN
    localparam logic [N-1:0] ACT_RST = '0;
`else
    localparam logic [N-1:0] ACT_RST = '1;
`endif

    freq_input_conditioner #(
        .INPUTS_COUNT    (N),
        .FILTER_LEN      (FL),
        .ACTIVITY_TIMEOUT(TO)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .F_raw          (F_raw),
        .filter_bypass_i(filter_bypass_i),
        .F_in           (F_in),
        .F_rise         (F_rise),
        .active_o       (active_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next active edge and settle before sampling or driving.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic exp_active(input logic monitored_level);
`ifdef FREQ_INPUT_ACTIVITY_EN
        return monitored_level;
`else
        return monitored_level | 1'b1;
`endif
    endfunction

    initial begin
        rst_i           = 1'b1;
        F_raw           = '0;
        filter_bypass_i = 1'b0;
        repeat (3) tick();
        check("rst_f_in",   32'(F_in),     32'(0));
        check("rst_f_rise", 32'(F_rise),   32'(0));
        check("rst_active", 32'(active_o), 32'(ACT_RST));
        rst_i = 1'b0;
        tick();

        // Filtered latency on channel 0: change before edge k, visible after edge k+5.
        F_raw[0] = 1'b1;
        for (int n = 0; n <= 7; n++) begin
            tick();
            check($sformatf("lat_f_in0_n%0d", n),  32'(F_in[0]),   32'(n >= 5));
            check($sformatf("lat_rise0_n%0d", n),  32'(F_rise[0]), 32'(n == 5));
        end
        check("lat_active0", 32'(active_o[0]), 32'(exp_active(1'b1)));

        // 3-cycle glitch on channel 5 is discarded.
        F_raw[5] = 1'b1;
        for (int n = 0; n <= 12; n++) begin
            if (n == 3) F_raw[5] = 1'b0;
            tick();
            check($sformatf("gl3_f_in5_n%0d", n), 32'(F_in[5]),   32'(0));
            check($sformatf("gl3_rise5_n%0d", n), 32'(F_rise[5]), 32'(0));
        end

        // 4-cycle pulse on channel 5 passes as a 4-cycle level.
        F_raw[5] = 1'b1;
        for (int n = 0; n <= 12; n++) begin
            if (n == 4) F_raw[5] = 1'b0;
            tick();
            check($sformatf("gl4_f_in5_n%0d", n), 32'(F_in[5]),   32'(n >= 5 && n <= 8));
            check($sformatf("gl4_rise5_n%0d", n), 32'(F_rise[5]), 32'(n == 5));
        end

        // Bypass: a 1-cycle pulse on channel 12 shows up 2 edges later for 1 cycle.
        filter_bypass_i = 1'b1;
        repeat (2) tick();
        F_raw[12] = 1'b1;
        for (int n = 0; n <= 5; n++) begin
            tick();
            if (n == 0) F_raw[12] = 1'b0;
            check($sformatf("byp_f_in12_n%0d", n), 32'(F_in[12]),   32'(n == 2));
            check($sformatf("byp_rise12_n%0d", n), 32'(F_rise[12]), 32'(n == 2));
        end

        // Reset mid-run with all channels toggling in bypass.
        F_raw = 24'hA5A5A5;
        for (int n = 0; n < 6; n++) begin
            tick();
            F_raw = ~F_raw;
        end
        check("busy_before_rst", 32'(F_in != '0), 32'(1));
        #2;
        rst_i = 1'b1;
        F_raw = '0;
        #1;
        check("mid_rst_f_in",   32'(F_in),     32'(0));
        check("mid_rst_f_rise", 32'(F_rise),   32'(0));
        check("mid_rst_active", 32'(active_o), 32'(ACT_RST));
        repeat (3) tick();
        rst_i = 1'b0;
        for (int n = 0; n < 8; n++) begin
            tick();
            check($sformatf("post_rst_rise_n%0d", n), 32'(F_rise), 32'(0));
        end
        check("post_rst_f_in",   32'(F_in),     32'(0));
        check("post_rst_active", 32'(active_o), 32'(ACT_RST));
        filter_bypass_i = 1'b0;

        // Activity on channel 23: rise at offset 5, active for exactly TO cycles.
        F_raw[23] = 1'b1;
        for (int n = 0; n <= 70; n++) begin
            tick();
            check($sformatf("act_a23_n%0d", n),  32'(active_o[23]), 32'(exp_active(n >= 5 && n <= 5 + TO - 1)));
            check($sformatf("act_r23_n%0d", n),  32'(F_rise[23]),   32'(n == 5));
        end

        // Drop the channel, then re-rise exactly in the timeout cycle.
        F_raw[23] = 1'b0;
        repeat (10) tick();
        check("act_fell_f_in23", 32'(F_in[23]), 32'(0));
        F_raw[23] = 1'b1;
        for (int n = 0; n <= 75; n++) begin
            tick();
            check($sformatf("tmo_a23_n%0d", n), 32'(active_o[23]), 32'(exp_active(n >= 5)));
            check($sformatf("tmo_r23_n%0d", n), 32'(F_rise[23]),   32'(n == 5 || n == 5 + TO));
            if (n == 10) F_raw[23] = 1'b0;
            if (n == 63) F_raw[23] = 1'b1;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
